mem_port_arbiter: RTL

//  Shares the single-port Memory among three requesters: exception-vector fetch (EXC),

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, requester indices and the sub-word merge helper for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RMW_WR = 2'd3
  } arb_state_t;

  localparam int REQ_EXC   = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_FETCH = 2;
  localparam int N_REQ     = 3;

  // Sub-word stores always land in the low lanes of the word read back.
  function automatic logic [31:0] merge_subword(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input size_t       size);
    case (size)
      SZ_BYTE: merge_subword = {word[31:8], wdata[7:0]};
      SZ_HALF: merge_subword = {word[31:16], wdata[15:0]};
      default: merge_subword = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: EXC first, then DATA/FETCH ordered by the round-robin pointer.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             rr_ptr,
  output logic [N_REQ-1:0] gnt_vec,
  output logic [1:0]       gnt_idx
);

  // rr_ptr high means FETCH wins a DATA/FETCH collision.
  always_comb begin
    gnt_vec = '0;
    gnt_idx = 2'(REQ_EXC);
    if (req[REQ_EXC]) begin
      gnt_vec[REQ_EXC] = 1'b1;
    end else if (req[REQ_DATA] && (!req[REQ_FETCH] || !rr_ptr)) begin
      gnt_vec[REQ_DATA] = 1'b1;
      gnt_idx           = 2'(REQ_DATA);
    end else if (req[REQ_FETCH]) begin
      gnt_vec[REQ_FETCH] = 1'b1;
      gnt_idx            = 2'(REQ_FETCH);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory among EXC, DATA and FETCH; sub-word stores are read-modify-write.
// Define MEM_ARB_RR_EN for round-robin between DATA and FETCH (default: fixed DATA > FETCH).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0][31:0] addr,
  input  logic [N_REQ-1:0]       we,
  input  logic [N_REQ-1:0][1:0]  size,
  input  logic [N_REQ-1:0][31:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [31:0]            rdata,
  output logic [31:0]            mem_addr,
  output logic                   mem_wr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic                   busy
);

  arb_state_t       state;
  logic             rr_ptr;
  logic [N_REQ-1:0] pick_vec;
  logic [1:0]       pick_idx;
  logic [N_REQ-1:0] lat_id;
  logic             lat_we;
  size_t            lat_size;
  logic [31:0]      lat_wdata;
  logic [1:0]       wait_cnt;
  logic             word_store;
  size_t            req_size;

  mem_arb_pick u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt_vec (pick_vec),
    .gnt_idx (pick_idx)
  );

  assign req_size   = size_t'(size[pick_idx]);
  assign word_store = lat_we && (lat_size == SZ_WORD);
  assign gnt        = (state == IDLE) ? pick_vec : '0;
  assign busy       = (state != IDLE);
  assign mem_wr     = ((state == ACCESS) && word_store) || (state == RMW_WR);

  // done is set on the transition back to IDLE so it pulses in the cycle the next grant can happen.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      done      <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_ptr    <= 1'b0;
      lat_id    <= '0;
      lat_we    <= 1'b0;
      lat_size  <= SZ_WORD;
      lat_wdata <= '0;
      wait_cnt  <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|pick_vec) begin
            lat_id    <= pick_vec;
            lat_we    <= we[pick_idx];
            lat_size  <= req_size;
            lat_wdata <= wdata[pick_idx];
            mem_addr  <= addr[pick_idx];
            if (we[pick_idx] && (req_size == SZ_WORD))
              mem_wdata <= wdata[pick_idx];
`ifdef MEM_ARB_RR_EN
            if (!pick_vec[REQ_EXC])
              rr_ptr <= pick_vec[REQ_DATA];
`endif
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (word_store) begin
            done  <= lat_id;
            state <= IDLE;
          end else begin
            wait_cnt <= 2'(RD_LAT - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (lat_we) begin
              mem_wdata <= merge_subword(mem_rdata, lat_wdata, lat_size);
              state     <= RMW_WR;
            end else begin
              rdata <= mem_rdata;
              done  <= lat_id;
              state <= IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RMW_WR: begin
          done  <= lat_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
